// File: rtl/sd_emmc_sdma_engine.sv
// sd_emmc_sdma_engine: moves whole blocks between the card data FIFOs and
// system memory. On the card->memory side a one-word output register feeds the
// memory write port. On the memory->card side at most one read is outstanding.
// The transfer stops at each SDMA buffer boundary until software reloads the
// system address.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start
// WR_RUN  | card->memory: pop rx FIFO, present memory writes
// RD_REQ  | memory->card: issue one read once the tx FIFO has room
// RD_WAIT | memory->card: wait for the read response, push it into tx
// BOUND   | stopped at a buffer boundary, waiting for sys_addr_load
// DONE    | last block finished, emit xfer_done
module sd_emmc_sdma_engine #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int BLKCNT_W = 16,
  parameter int BLKSZ_W  = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                dir,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   sys_addr,
  input  logic                sys_addr_load,
  input  logic [2:0]          buf_boundary,
  input  logic [BLKCNT_W-1:0] block_count,
  input  logic [BLKSZ_W-1:0]  block_size,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_empty,
  output logic                rx_rd,
  output logic [DATA_W-1:0]   tx_data,
  input  logic                tx_full,
  output logic                tx_wr,
  output logic [ADDR_W-1:0]   m_wr_addr,
  output logic [DATA_W-1:0]   m_wr_data,
  output logic                m_wr_valid,
  input  logic                m_wr_ready,
  output logic [ADDR_W-1:0]   m_rd_addr,
  output logic                m_rd_valid,
  input  logic                m_rd_ready,
  input  logic [DATA_W-1:0]   m_rd_data,
  input  logic                m_rd_rvalid,
  output logic                busy,
  output logic                dma_int,
  output logic                xfer_done,
  output logic [BLKCNT_W-1:0] blocks_done
);

  localparam int BYTES = DATA_W / 8;
  localparam int BSH   = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_RUN,
    S_RD_REQ,
    S_RD_WAIT,
    S_BOUND,
    S_DONE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cur_addr;
  logic [BLKSZ_W-1:0]  word_cnt;
  logic [BLKSZ_W-1:0]  words_per_blk;
  logic [BLKCNT_W-1:0] blk_total;
  logic [2:0]          bound_sel;
  logic                dir_lat;

  logic                wr_drain;
  logic                word_done;
  logic [ADDR_W-1:0]   addr_next;
  logic                word_last;
  logic                blk_last;
  logic                done_now;
  logic                bound_now;
  logic [ADDR_W-1:0]   bound_mask;

  // Boundary mask: low (12 + buf_boundary) address bits must be zero at a stop.
  always_comb begin
    bound_mask = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      bound_mask[i] = (i < 12 + int'(bound_sel));
    end
  end

  // Word completion, block/transfer end and boundary detection.
  always_comb begin
    wr_drain  = m_wr_valid & m_wr_ready;
    word_done = ((state == S_WR_RUN) & wr_drain) |
                ((state == S_RD_WAIT) & m_rd_rvalid);
    addr_next = cur_addr + ADDR_W'(BYTES);
    word_last = ((word_cnt + BLKSZ_W'(1)) == words_per_blk);
    blk_last  = word_last && ((blocks_done + BLKCNT_W'(1)) == blk_total);
    done_now  = word_done & blk_last;
    bound_now = word_done & ~blk_last & ((addr_next & bound_mask) == '0);
  end

  // rx pop: fill the output register when it is empty, or refill it while it
  // drains unless that drain ends the transfer or hits a boundary.
  always_comb begin
    rx_rd = (state == S_WR_RUN) & ~abort & ~rx_empty &
            (~m_wr_valid | (wr_drain & ~done_now & ~bound_now));
  end

  // Main controller: state, address/count tracking and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= S_IDLE;
      cur_addr      <= '0;
      word_cnt      <= '0;
      words_per_blk <= '0;
      blk_total     <= '0;
      bound_sel     <= '0;
      dir_lat       <= 1'b0;
      tx_data       <= '0;
      tx_wr         <= 1'b0;
      m_wr_addr     <= '0;
      m_wr_data     <= '0;
      m_wr_valid    <= 1'b0;
      m_rd_addr     <= '0;
      m_rd_valid    <= 1'b0;
      busy          <= 1'b0;
      dma_int       <= 1'b0;
      xfer_done     <= 1'b0;
      blocks_done   <= '0;
    end else begin
      dma_int   <= 1'b0;
      xfer_done <= 1'b0;
      tx_wr     <= 1'b0;
      if (abort && state != S_IDLE) begin
        // In-flight memory handshakes are simply dropped.
        state      <= S_IDLE;
        m_wr_valid <= 1'b0;
        m_rd_valid <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            busy <= 1'b0;
            if (start) begin
              cur_addr      <= sys_addr;
              blocks_done   <= '0;
              word_cnt      <= '0;
              words_per_blk <= block_size >> BSH;
              blk_total     <= block_count;
              bound_sel     <= buf_boundary;
              dir_lat       <= dir;
              busy          <= 1'b1;
              if (block_count == '0) begin
                state <= S_DONE;
              end else if (dir) begin
                state <= S_WR_RUN;
              end else begin
                state <= S_RD_REQ;
              end
            end
          end
          S_WR_RUN: begin
            if (rx_rd) begin
              // A word loaded while the previous one drains goes to the next address.
              m_wr_valid <= 1'b1;
              m_wr_addr  <= wr_drain ? addr_next : cur_addr;
              m_wr_data  <= rx_data;
            end else if (wr_drain) begin
              m_wr_valid <= 1'b0;
            end
            if (done_now) begin
              state <= S_DONE;
            end else if (bound_now) begin
              state   <= S_BOUND;
              dma_int <= 1'b1;
            end
          end
          S_RD_REQ: begin
            if (m_rd_valid) begin
              if (m_rd_ready) begin
                m_rd_valid <= 1'b0;
                state      <= S_RD_WAIT;
              end
            end else if (!tx_full) begin
              m_rd_valid <= 1'b1;
              m_rd_addr  <= cur_addr;
            end
          end
          S_RD_WAIT: begin
            if (m_rd_rvalid) begin
              tx_wr   <= 1'b1;
              tx_data <= m_rd_data;
              if (done_now) begin
                state <= S_DONE;
              end else if (bound_now) begin
                state   <= S_BOUND;
                dma_int <= 1'b1;
              end else begin
                state <= S_RD_REQ;
              end
            end
          end
          S_BOUND: begin
            if (sys_addr_load) begin
              cur_addr <= sys_addr;
              state    <= dir_lat ? S_WR_RUN : S_RD_REQ;
            end
          end
          S_DONE: begin
            // busy stays high for this cycle and drops once back in IDLE.
            xfer_done <= 1'b1;
            state     <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase

        if (word_done) begin
          cur_addr <= addr_next;
          if (word_last) begin
            word_cnt    <= '0;
            blocks_done <= blocks_done + BLKCNT_W'(1);
          end else begin
            word_cnt <= word_cnt + BLKSZ_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_emmc_sdma_engine.sv
// Scoreboard bench for sd_emmc_sdma_engine: FIFO and memory models drive the
// DUT, expected writes / read addresses / tx words are queued up front and
// popped as the DUT produces them.
module tb_sd_emmc_sdma_engine;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int BLKCNT_W = 16;
  localparam int BLKSZ_W  = 12;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic                dir = 1'b0;
  logic                abort = 1'b0;
  logic [ADDR_W-1:0]   sys_addr = '0;
  logic                sys_addr_load = 1'b0;
  logic [2:0]          buf_boundary = '0;
  logic [BLKCNT_W-1:0] block_count = '0;
  logic [BLKSZ_W-1:0]  block_size = '0;
  logic [DATA_W-1:0]   rx_data = '0;
  logic                rx_empty = 1'b1;
  logic                rx_rd;
  logic [DATA_W-1:0]   tx_data;
  logic                tx_full = 1'b0;
  logic                tx_wr;
  logic [ADDR_W-1:0]   m_wr_addr;
  logic [DATA_W-1:0]   m_wr_data;
  logic                m_wr_valid;
  logic                m_wr_ready = 1'b0;
  logic [ADDR_W-1:0]   m_rd_addr;
  logic                m_rd_valid;
  logic                m_rd_ready = 1'b0;
  logic [DATA_W-1:0]   m_rd_data = '0;
  logic                m_rd_rvalid = 1'b0;
  logic                busy;
  logic                dma_int;
  logic                xfer_done;
  logic [BLKCNT_W-1:0] blocks_done;

  sd_emmc_sdma_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BLKCNT_W(BLKCNT_W), .BLKSZ_W(BLKSZ_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .dir(dir), .abort(abort),
    .sys_addr(sys_addr), .sys_addr_load(sys_addr_load), .buf_boundary(buf_boundary),
    .block_count(block_count), .block_size(block_size),
    .rx_data(rx_data), .rx_empty(rx_empty), .rx_rd(rx_rd),
    .tx_data(tx_data), .tx_full(tx_full), .tx_wr(tx_wr),
    .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_valid(m_wr_valid),
    .m_wr_ready(m_wr_ready),
    .m_rd_addr(m_rd_addr), .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready),
    .m_rd_data(m_rd_data), .m_rd_rvalid(m_rd_rvalid),
    .busy(busy), .dma_int(dma_int), .xfer_done(xfer_done), .blocks_done(blocks_done)
  );

  always #5 clock = ~clock;

  logic [63:0] exp_wr[$];
  logic [31:0] exp_rd_addr[$];
  logic [31:0] exp_tx[$];
  logic [31:0] rx_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int tx_cnt = 0;
  int xfer_cnt = 0;
  int dma_cnt = 0;

  bit wr_ready_en = 1'b1;
  bit rd_rand = 1'b0;
  bit tx_toggle = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h3C5A, ~a[15:0]};
  endfunction

  task automatic prepare_write(input logic [31:0] base, input int n, input logic [31:0] seed);
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      d = seed + 32'(i * 7);
      rx_q.push_back(d);
      exp_wr.push_back({base + 32'(i * 4), d});
    end
  endtask

  task automatic prepare_read(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_rd_addr.push_back(base + 32'(i * 4));
      exp_tx.push_back(mem_word(base + 32'(i * 4)));
    end
  endtask

  task automatic configure(input logic d, input logic [31:0] a, input logic [2:0] bb,
                           input int cnt, input int sz);
    dir          = d;
    sys_addr     = a;
    buf_boundary = bb;
    block_count  = BLKCNT_W'(cnt);
    block_size   = BLKSZ_W'(sz);
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clock); #1 abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
  endtask

  task automatic pulse_load();
    @(posedge clock); #1 sys_addr_load = 1'b1;
    @(posedge clock); #1 sys_addr_load = 1'b0;
  endtask

  task automatic wait_xfer(input int base, input int budget, input string tag);
    int n = 0;
    while (xfer_cnt == base && n < budget) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    check_val(tag, 64'(xfer_cnt - base), 64'(1));
  endtask

  task automatic wait_dma(input int base, input int budget, input string tag);
    int n = 0;
    while (dma_cnt == base && n < budget) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    check_val(tag, 64'(dma_cnt - base), 64'(1));
  endtask

  task automatic wait_wr(input int target, input int budget, input string tag);
    int n = 0;
    while (wr_cnt < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check_val(tag, 64'(wr_cnt >= target), 64'(1));
  endtask

  // Monitor and input models: sample at negedge, update inputs 1 after posedge.
  initial begin
    bit          pop_rx;
    bit          rd_accept;
    bit          rd_pending;
    int          rd_lat;
    logic [31:0] rd_resp_addr;
    logic [31:0] acc_addr;
    bit          prev_rd_valid;
    bit          prev_tx_full;
    int          tog;
    rd_pending = 1'b0; rd_lat = 0; rd_resp_addr = '0; acc_addr = '0;
    prev_rd_valid = 1'b0; prev_tx_full = 1'b0; tog = 0;
    forever begin
      @(negedge clock);
      pop_rx    = 1'b0;
      rd_accept = 1'b0;
      if (m_wr_valid) begin
        if (exp_wr.size() == 0) begin
          check_val("wr_unexpected", 64'(m_wr_valid), 64'(0));
        end else begin
          check_val("wr_word", {m_wr_addr, m_wr_data}, exp_wr[0]);
          if (m_wr_ready) begin
            void'(exp_wr.pop_front());
            wr_cnt++;
          end
        end
        if (!m_wr_ready) check_val("wr_stall_pop", 64'(rx_rd), 64'(0));
      end
      if (rx_rd) begin
        if (rx_q.size() == 0) check_val("rx_underflow", 64'(rx_rd), 64'(0));
        else pop_rx = 1'b1;
      end
      if (m_rd_valid && !prev_rd_valid)
        check_val("rd_req_while_full", 64'(prev_tx_full), 64'(0));
      if (m_rd_valid && m_rd_ready) begin
        rd_accept = 1'b1;
        acc_addr  = m_rd_addr;
        rd_cnt++;
        if (exp_rd_addr.size() == 0) check_val("rd_unexpected", 64'(m_rd_valid), 64'(0));
        else check_val("rd_addr", 64'(m_rd_addr), 64'(exp_rd_addr.pop_front()));
      end
      if (tx_wr) begin
        tx_cnt++;
        if (exp_tx.size() == 0) check_val("tx_unexpected", 64'(tx_wr), 64'(0));
        else check_val("tx_data", 64'(tx_data), 64'(exp_tx.pop_front()));
      end
      if (xfer_done) xfer_cnt++;
      if (dma_int) dma_cnt++;
      prev_rd_valid = m_rd_valid;
      prev_tx_full  = tx_full;

      @(posedge clock);
      #1;
      if (pop_rx) void'(rx_q.pop_front());
      rx_empty   = (rx_q.size() == 0);
      rx_data    = (rx_q.size() != 0) ? rx_q[0] : '0;
      m_wr_ready = wr_ready_en;
      m_rd_ready = rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      m_rd_rvalid = 1'b0;
      if (rd_accept) begin
        rd_pending   = 1'b1;
        rd_resp_addr = acc_addr;
        rd_lat       = rd_rand ? int'($urandom_range(0, 3)) : 0;
      end
      if (rd_pending) begin
        if (rd_lat == 0) begin
          m_rd_rvalid = 1'b1;
          m_rd_data   = mem_word(rd_resp_addr);
          rd_pending  = 1'b0;
        end else begin
          rd_lat--;
        end
      end
      if (tx_toggle) begin
        tog++;
        if (tog == 3) begin
          tx_full = ~tx_full;
          tog     = 0;
        end
      end else begin
        tx_full = 1'b0;
        tog     = 0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_x;
    int base_d;
    int base_w;
    int base_r;

    // Reset values
    repeat (3) @(negedge clock);
    check_val("rst_ctrl", 64'({rx_rd, tx_wr, m_wr_valid, m_rd_valid, busy, dma_int, xfer_done}), 64'(0));
    check_val("rst_addr", {m_wr_addr, m_rd_addr}, 64'(0));
    check_val("rst_data", {m_wr_data, tx_data}, 64'(0));
    check_val("rst_blocks", 64'(blocks_done), 64'(0));
    @(posedge clock); #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    check_val("idle_busy", 64'(busy), 64'(0));

    // Card->memory, 2 blocks of 512 bytes
    base_x = xfer_cnt; base_d = dma_cnt; base_w = wr_cnt;
    configure(1'b1, 32'h1000_0000, 3'd7, 2, 512);
    prepare_write(32'h1000_0000, 256, 32'hC0DE_0000);
    pulse_start();
    @(negedge clock);
    check_val("t1_busy", 64'(busy), 64'(1));
    check_val("t1_first_valid", 64'(m_wr_valid), 64'(0));
    wait_xfer(base_x, 2000, "t1_done");
    check_val("t1_writes", 64'(wr_cnt - base_w), 64'(256));
    check_val("t1_blocks", 64'(blocks_done), 64'(2));
    check_val("t1_sb_empty", 64'(exp_wr.size()), 64'(0));
    check_val("t1_no_dma", 64'(dma_cnt - base_d), 64'(0));
    @(negedge clock);
    check_val("t1_busy_drop", 64'(busy), 64'(0));

    // Boundary stop at 4 KiB, resume at a new address
    base_x = xfer_cnt; base_d = dma_cnt; base_w = wr_cnt;
    configure(1'b1, 32'h0000_0E00, 3'd0, 16, 128);
    prepare_write(32'h0000_0E00, 128, 32'h1111_0000);
    prepare_write(32'h2000_0000, 384, 32'h2222_0000);
    pulse_start();
    wait_dma(base_d, 2000, "t2_dma");
    check_val("t2_blocks_at_bound", 64'(blocks_done), 64'(4));
    check_val("t2_words_at_bound", 64'(wr_cnt - base_w), 64'(128));
    check_val("t2_busy_bound", 64'(busy), 64'(1));
    sys_addr = 32'h2000_0000;
    pulse_load();
    wait_xfer(base_x, 4000, "t2_done");
    check_val("t2_writes", 64'(wr_cnt - base_w), 64'(512));
    check_val("t2_blocks", 64'(blocks_done), 64'(16));
    check_val("t2_dma_once", 64'(dma_cnt - base_d), 64'(1));
    check_val("t2_sb_empty", 64'(exp_wr.size()), 64'(0));

    // Memory->card, tx_full toggling, random ready and response latency
    base_x = xfer_cnt; base_r = rd_cnt;
    tx_toggle = 1'b1; rd_rand = 1'b1;
    configure(1'b0, 32'h0000_0000, 3'd0, 1, 512);
    prepare_read(32'h0000_0000, 128);
    pulse_start();
    wait_xfer(base_x, 6000, "t3_done");
    check_val("t3_reads", 64'(rd_cnt - base_r), 64'(128));
    check_val("t3_tx_empty", 64'(exp_tx.size()), 64'(0));
    check_val("t3_blocks", 64'(blocks_done), 64'(1));
    tx_toggle = 1'b0; rd_rand = 1'b0;
    repeat (3) @(negedge clock);

    // Write back-pressure: ready held low ~10 cycles
    base_x = xfer_cnt; base_w = wr_cnt;
    wr_ready_en = 1'b0;
    configure(1'b1, 32'h3000_0000, 3'd0, 1, 64);
    prepare_write(32'h3000_0000, 16, 32'h3333_0000);
    pulse_start();
    repeat (10) @(negedge clock);
    check_val("t4_stall_valid", 64'(m_wr_valid), 64'(1));
    check_val("t4_stall_word", {m_wr_addr, m_wr_data}, {32'h3000_0000, 32'h3333_0000});
    wr_ready_en = 1'b1;
    wait_xfer(base_x, 500, "t4_done");
    check_val("t4_writes", 64'(wr_cnt - base_w), 64'(16));

    // Abort in block 1 of 3, then a normal transfer
    base_x = xfer_cnt; base_w = wr_cnt;
    configure(1'b1, 32'h4000_0000, 3'd0, 3, 64);
    prepare_write(32'h4000_0000, 48, 32'h4444_0000);
    pulse_start();
    wait_wr(base_w + 20, 500, "t5_reach_blk1");
    pulse_abort();
    @(negedge clock);
    check_val("t5_abort_idle", 64'({busy, m_wr_valid, rx_rd}), 64'(0));
    repeat (5) @(negedge clock);
    check_val("t5_no_done", 64'(xfer_cnt - base_x), 64'(0));
    rx_q.delete();
    exp_wr.delete();
    repeat (2) @(negedge clock);
    base_x = xfer_cnt; base_w = wr_cnt;
    configure(1'b1, 32'h5000_0000, 3'd0, 1, 64);
    prepare_write(32'h5000_0000, 16, 32'h5555_0000);
    pulse_start();
    wait_xfer(base_x, 500, "t5_restart_done");
    check_val("t5_restart_writes", 64'(wr_cnt - base_w), 64'(16));
    check_val("t5_restart_blocks", 64'(blocks_done), 64'(1));

    // Zero block count: done two cycles after start, no traffic
    base_w = wr_cnt; base_r = rd_cnt;
    configure(1'b1, 32'h6000_0000, 3'd0, 0, 64);
    pulse_start();
    @(negedge clock);
    check_val("t6_zero_c1", 64'({busy, xfer_done}), 64'(2'b10));
    @(negedge clock);
    check_val("t6_zero_c2", 64'({busy, xfer_done}), 64'(2'b11));
    @(negedge clock);
    check_val("t6_zero_c3", 64'({busy, xfer_done}), 64'(2'b00));
    check_val("t6_zero_traffic", 64'((wr_cnt - base_w) + (rd_cnt - base_r)), 64'(0));
    check_val("t6_zero_blocks", 64'(blocks_done), 64'(0));

    // Boundary coincides with the last word: completion wins
    base_x = xfer_cnt; base_d = dma_cnt;
    configure(1'b1, 32'h0000_0F00, 3'd0, 1, 256);
    prepare_write(32'h0000_0F00, 64, 32'h7777_0000);
    pulse_start();
    wait_xfer(base_x, 500, "t6_last_done");
    check_val("t6_last_no_dma", 64'(dma_cnt - base_d), 64'(0));
    check_val("t6_last_sb_empty", 64'(exp_wr.size()), 64'(0));
    repeat (2) @(negedge clock);
    check_val("t6_last_idle", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
